// File: rtl/pwm_capture_if.sv
// PWM capture port bundle: the measured input plus the measurement results.
// master drives PwmIn and observes results; slave is the capture block.
interface pwm_capture_if #(
   parameter int SIZE = 21
);
   logic            PwmIn;
   logic [SIZE-1:0] Width;
   logic [SIZE-1:0] Period;
   logic            Valid;
   logic            Timeout;
   logic            Level;

   modport master (
      output PwmIn,
      input  Width,
      input  Period,
      input  Valid,
      input  Timeout,
      input  Level
   );

   modport slave (
      input  PwmIn,
      output Width,
      output Period,
      output Valid,
      output Timeout,
      output Level
   );
endinterface

// File: rtl/pwm_capture.sv
// PWM width/period capture; Valid 3 clk after the closing PwmIn rise (7 with
// PWM_CAPTURE_GLITCH_FILTER_EN defined); no backpressure, results simply overwrite.
module pwm_capture #(
   parameter int SIZE      = 21,
   parameter int MAX_COUNT = 2000000
) (
   input  logic              clk,
   input  logic              rst_n,
   pwm_capture_if.slave      bus
);

   localparam logic [SIZE-1:0] MAX_CNT = SIZE'(MAX_COUNT);
   localparam logic [SIZE-1:0] ONE     = SIZE'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HIGH,
      S_LOW
   } state_t;

   logic            sync1;
   logic            sync2;
   logic            lvl;
   logic            lvl_prev;
   logic            rise;
   logic            fall;

   state_t          state;
   logic [SIZE-1:0] cnt;
   logic [SIZE-1:0] high_time;
   logic [SIZE-1:0] width_q;
   logic [SIZE-1:0] period_q;
   logic            valid_q;
   logic            timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= bus.PwmIn;
         sync2 <= sync1;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic       filt;
   logic [1:0] stab_cnt;

   // Level follows the synchronizer only after it has disagreed for 4 straight cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt     <= 1'b0;
         stab_cnt <= 2'd0;
      end else if (sync2 == filt) begin
         stab_cnt <= 2'd0;
      end else if (stab_cnt == 2'd3) begin
         filt     <= sync2;
         stab_cnt <= 2'd0;
      end else begin
         stab_cnt <= stab_cnt + 2'd1;
      end
   end

   assign lvl = filt;
`else
   assign lvl = sync2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_prev <= 1'b0;
      end else begin
         lvl_prev <= lvl;
      end
   end

   assign rise = lvl & ~lvl_prev;
   assign fall = ~lvl & lvl_prev;

   // An edge on the same cycle the counter hits its limit wins over the timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         high_time <= '0;
         width_q   <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rise) begin
                  state <= S_HIGH;
                  cnt   <= ONE;
               end else begin
                  cnt <= '0;
               end
            end
            S_HIGH: begin
               if (fall) begin
                  high_time <= cnt;
                  state     <= S_LOW;
                  cnt       <= (cnt >= MAX_CNT) ? MAX_CNT : cnt + ONE;
               end else if (cnt >= MAX_CNT) begin
                  timeout_q <= 1'b1;
                  state     <= S_IDLE;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            S_LOW: begin
               if (rise) begin
                  period_q  <= cnt;
                  width_q   <= high_time;
                  valid_q   <= 1'b1;
                  timeout_q <= 1'b0;
                  state     <= S_HIGH;
                  cnt       <= ONE;
               end else if (cnt >= MAX_CNT) begin
                  timeout_q <= 1'b1;
                  state     <= S_IDLE;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.Width   = width_q;
   assign bus.Period  = period_q;
   assign bus.Valid   = valid_q;
   assign bus.Timeout = timeout_q;
   assign bus.Level   = lvl;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a shortened timeout limit; waveform vectors plus corner sequences.
module tb_pwm_capture;

   localparam int SZ   = 16;
   localparam int MAXC = 5000;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int SMALL_N = 0;
   localparam int G_N     = 2;
   localparam int G_W     = 100;
   localparam int G_P     = 400;
`else
   localparam int SMALL_N = 2;
   localparam int G_N     = 3;
   localparam int G_W     = 100;
   localparam int G_P     = 200;
`endif

   typedef struct {
      int w;
      int p;
      int n;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pwm_capture_if #(.SIZE(SZ)) bus ();

   pwm_capture #(
      .SIZE      (SZ),
      .MAX_COUNT (MAXC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int vw[$];
   int vp[$];
   int stab_err = 0;
   logic [SZ-1:0] pw = '0;
   logic [SZ-1:0] pp = '0;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.Valid === 1'b1) begin
            vw.push_back(int'(bus.Width));
            vp.push_back(int'(bus.Period));
         end else if (bus.Width !== pw || bus.Period !== pp) begin
            stab_err++;
         end
      end
      pw = bus.Width;
      pp = bus.Period;
   end

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      bus.PwmIn = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      bus.PwmIn = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      vw.delete();
      vp.delete();
      @(negedge clk);
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{w: 1000, p: 4000, n: 2};
      vecs[1] = '{w: 4,    p: 10,   n: 2};
      vecs[2] = '{w: 1,    p: 2,    n: SMALL_N};
      vecs[3] = '{w: 2,    p: 3,    n: SMALL_N};
      vecs[4] = '{w: 50,   p: 200,  n: 2};
      vecs[5] = '{w: 4,    p: 8,    n: 2};
      vecs[6] = '{w: 150,  p: 2000, n: 2};
      vecs[7] = '{w: 1,    p: 5,    n: SMALL_N};

      bus.PwmIn = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      check("reset Width",   int'(bus.Width),   0);
      check("reset Period",  int'(bus.Period),  0);
      check("reset Valid",   int'(bus.Valid),   0);
      check("reset Timeout", int'(bus.Timeout), 0);
      check("reset Level",   int'(bus.Level),   0);
      rst_n = 1'b1;
      @(negedge clk);

      // Three periods per vector: the first rise only arms, the next two report.
      for (int i = 0; i < 8; i++) begin
         do_reset();
         hold(1'b0, 5);
         for (int k = 0; k < 3; k++) begin
            hold(1'b1, vecs[i].w);
            hold(1'b0, vecs[i].p - vecs[i].w);
         end
         hold(1'b0, 12);
         check($sformatf("vec%0d valid count", i), vw.size(), vecs[i].n);
         for (int j = 0; j < vecs[i].n; j++) begin
            if (j < vw.size()) begin
               check($sformatf("vec%0d Width[%0d]", i, j),  vw[j], vecs[i].w);
               check($sformatf("vec%0d Period[%0d]", i, j), vp[j], vecs[i].p);
            end
         end
         check($sformatf("vec%0d Timeout", i), int'(bus.Timeout), 0);
      end

      // Timeout with input stuck high, then recovery on the next full period.
      do_reset();
      hold(1'b0, 5);
      for (int k = 0; k < 2; k++) begin
         hold(1'b1, 20);
         hold(1'b0, 60);
      end
      hold(1'b1, MAXC + 20);
      check("stuck Timeout",     int'(bus.Timeout), 1);
      check("stuck Level",       int'(bus.Level),   1);
      check("stuck Width hold",  int'(bus.Width),   20);
      check("stuck Period hold", int'(bus.Period),  80);
      check("stuck valid count", vw.size(), 2);
      hold(1'b0, 60);
      hold(1'b1, 30);
      hold(1'b0, 70);
      hold(1'b1, 10);
      hold(1'b0, 12);
      check("recover valid count", vw.size(), 3);
      if (vw.size() == 3) begin
         check("recover Width",  vw[2], 30);
         check("recover Period", vp[2], 100);
      end
      check("recover Timeout", int'(bus.Timeout), 0);

      // Reset in the middle of a period abandons it.
      do_reset();
      hold(1'b0, 5);
      hold(1'b1, 100);
      hold(1'b0, 300);
      hold(1'b1, 100);
      hold(1'b0, 50);
      check("pre-reset Width", int'(bus.Width), 100);
      rst_n = 1'b0;
      hold(1'b0, 50);
      check("mid reset Width",   int'(bus.Width),   0);
      check("mid reset Period",  int'(bus.Period),  0);
      check("mid reset Valid",   int'(bus.Valid),   0);
      check("mid reset Timeout", int'(bus.Timeout), 0);
      rst_n = 1'b1;
      vw.delete();
      vp.delete();
      hold(1'b0, 250);
      hold(1'b1, 100);
      hold(1'b0, 300);
      check("post-reset first rise no valid", vw.size(), 0);
      hold(1'b1, 100);
      hold(1'b0, 12);
      check("post-reset valid count", vw.size(), 1);
      if (vw.size() == 1) begin
         check("post-reset Width",  vw[0], 100);
         check("post-reset Period", vp[0], 400);
      end

      // Release with the input already high: armed but never a Valid.
      rst_n     = 1'b0;
      bus.PwmIn = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      vw.delete();
      vp.delete();
      repeat (20) @(negedge clk);
      check("high-at-release valid count", vw.size(), 0);
      check("high-at-release Level", int'(bus.Level), 1);

      // Two-cycle glitch inside the low phase.
      do_reset();
      hold(1'b0, 5);
      hold(1'b1, 100);
      hold(1'b0, 100);
      hold(1'b1, 2);
      hold(1'b0, 198);
      hold(1'b1, 100);
      hold(1'b0, 300);
      hold(1'b1, 10);
      hold(1'b0, 12);
      check("glitch valid count", vw.size(), G_N);
      if (vw.size() > 0) begin
         check("glitch Width",  vw[0], G_W);
         check("glitch Period", vp[0], G_P);
      end

      check("Width/Period stable without Valid", stab_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SIZE, default 21, width of the cycle counter and of the Width and Period outputs.
REQ-002 MAX_COUNT, default 2000000, timeout limit in clk cycles with no edge; must satisfy MAX_COUNT < 2^SIZE.
REQ-003 clk  input  1  system clock (100 MHz); all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 PwmIn  input  1  asynchronous PWM signal to measure, e.g. servo, H-bridge enable or sensor pulse train.
REQ-006 Width  output  SIZE  high time of the last complete period, in clk cycles.
REQ-007 Period  output  SIZE  rising-to-rising time of the last complete period, in clk cycles.
REQ-008 Valid  output  1  one-cycle pulse when Width and Period update.
REQ-009 Timeout  output  1  level flag; no edge was seen for MAX_COUNT cycles.
REQ-010 Level  output  1  synchronized (and, if enabled, filtered) PwmIn, for 0%/100% duty reporting.

Function
REQ-011 PwmIn shall pass through a 2-flop synchronizer; edge detection shall compare the synchronized value against its value one cycle earlier.
REQ-012 The state machine shall have three states:
- IDLE: waiting for the first rising edge.
- HIGH: counting from a rising edge.
- LOW: counting from a falling edge.
REQ-013 IDLE -> HIGH on a detected rising edge; the counter loads 1.
REQ-014 HIGH -> LOW on a detected falling edge; the high-time register captures the counter value; the counter continues to increment.
REQ-015 LOW -> HIGH on a detected rising edge. On the same edge:
- Period <= counter value.
- Width <= high-time register.
- Valid = 1 for one cycle.
- Timeout cleared.
- Counter reloads 1.
REQ-016 A falling edge detected in IDLE shall be ignored.
REQ-017 The first rising edge after IDLE shall not assert Valid; only a complete period (rise, fall, rise) produces a measurement.
REQ-018 In HIGH or LOW, if the counter reaches MAX_COUNT with no edge:
- Timeout <= 1.
- Go to IDLE.
- Width and Period hold their previous values.
- Valid stays 0.
REQ-019 The counter shall never exceed MAX_COUNT; there is no wrap-around.
REQ-020 Valid shall be asserted exactly one clk cycle after the cycle in which the closing rising edge is detected; total latency from the PwmIn rising edge is 3 clk cycles (filter disabled).
REQ-021 Width and Period shall be stable whenever Valid is 0, and shall change only in the cycle Valid is 1.
REQ-022 A measured period of 1 or 2 cycles shall be reported as counted, without special-casing; Width is always less than Period.

Reset
REQ-023 While rst_n=0, asynchronously:
- Synchronizer flops = 0, Level = 0.
- State = IDLE, counter = 0, high-time register = 0.
- Width = 0, Period = 0, Valid = 0, Timeout = 0.
REQ-024 Reset asserted mid-period shall abandon the partial measurement; after release, the next complete period is measured normally.
REQ-025 A rising edge shall not be falsely detected on the first cycle after reset release when PwmIn is already high; the detector's previous-value flop resets to 0, and this is accepted as a rising edge into HIGH only, never into Valid.

Configuration
REQ-026 With PWM_CAPTURE_GLITCH_FILTER_EN defined:
- A 4-cycle stability filter follows the synchronizer.
- The filtered level changes only after the synchronized input holds a new value for 4 consecutive cycles.
- Pulses shorter than 4 cycles are suppressed.
- Latency becomes 7 cycles.
- Measured Width and Period are unchanged for clean inputs.
REQ-027 Without PWM_CAPTURE_GLITCH_FILTER_EN:
- No filter.
- Edges are taken directly from the synchronizer.
- Latency is 3 cycles.

Verification
REQ-028 PwmIn high 1000 cycles, period 4000, three periods -> two Valid pulses, each with Width=1000 and Period=4000; no Valid on the first edge.
REQ-029 Servo-style input, high 150000 cycles, period 2000000 -> Width=150000, Period=2000000, Timeout=0.
REQ-030 PwmIn held high after one rising edge for 2000000+ cycles -> Timeout=1, Level=1, Width and Period hold. The next full period clears Timeout and reports correctly.
REQ-031 rst_n pulsed low 500 cycles into a 4000-cycle period -> all outputs 0. The first Valid follows the second complete rising edge after release.
REQ-032 Filter enabled, 2-cycle glitch in the low phase of a 1000/4000 waveform -> Width=1000, Period=4000. Filter disabled, same stimulus -> glitch measured as a period.
